text_term: RTL and testbench

Character-stream terminal writer that fills the 40x30 text display memory consumed by the text renderer. It accepts ASCII bytes over a valid/ready handshake, keeps a cursor, writes glyph codes at address `row*40 + col`, and performs wrap, scroll, backspace and clear-screen. It owns the write port of the display memory; the renderer only reads it.

---
 rtl/text_term.sv | 194 +++++++++++++++++++
 tb/tb_text_term.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_term.sv
// Character-stream terminal writer for the 40x30 text display memory.
// Owns the memory write port: cursor tracking, wrap, scroll, backspace and clear.
module text_term (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [11:0] dis_addr,
  output logic [7:0]  dis_wdata,
  output logic        dis_we,
  output logic        dis_en,
  input  logic [7:0]  dis_rdata,
  output logic [5:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  localparam logic [7:0]  BLANK     = 8'h20;
  localparam logic [5:0]  LAST_COL  = 6'd39;
  localparam logic [4:0]  LAST_ROW  = 5'd29;
  localparam logic [10:0] COPY_LAST = 11'd1159;
  localparam logic [10:0] CELL_LAST = 11'd1199;

  typedef enum logic [2:0] {IDLE, EXEC, SCROLL_RD, SCROLL_WR, SCROLL_CLR, CLEAR} state_t;

  state_t      state, state_nxt;
  state_t      after, after_nxt;
  logic [10:0] idx, idx_nxt;
  logic [5:0]  x_nxt;
  logic [4:0]  y_nxt;
  logic [11:0] addr_nxt;
  logic [7:0]  wdata, wdata_nxt;
  logic        we_nxt;
  logic        en_nxt;
  logic        accept;

  // Cell address y*40 + x built from shifts; never exceeds 1199.
  function automatic logic [11:0] cell_addr(input logic [4:0] y, input logic [5:0] x);
    return ({7'd0, y} << 5) + ({7'd0, y} << 3) + {6'd0, x};
  endfunction

  assign accept    = char_valid && char_ready;
  // During the copy the read data is forwarded straight to the write port.
  assign dis_wdata = (state == SCROLL_WR) ? dis_rdata : wdata;

  // Next-state, cursor and next memory-port values.
  always_comb begin
    state_nxt = state;
    after_nxt = after;
    idx_nxt   = idx;
    x_nxt     = cursor_x;
    y_nxt     = cursor_y;
    addr_nxt  = dis_addr;
    wdata_nxt = wdata;
    we_nxt    = 1'b0;
    en_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = EXEC;
          after_nxt = IDLE;
          if ((char_in >= 8'h20) && (char_in <= 8'h7E)) begin
            addr_nxt  = cell_addr(cursor_y, cursor_x);
            wdata_nxt = char_in;
            we_nxt    = 1'b1;
            en_nxt    = 1'b1;
            if (cursor_x == LAST_COL) begin
              x_nxt = 6'd0;
              if (cursor_y == LAST_ROW) after_nxt = SCROLL_RD;
              else                      y_nxt     = cursor_y + 5'd1;
            end else begin
              x_nxt = cursor_x + 6'd1;
            end
          end else begin
            case (char_in)
              8'h0D: x_nxt = 6'd0;
              8'h0A: begin
                x_nxt = 6'd0;
                if (cursor_y == LAST_ROW) after_nxt = SCROLL_RD;
                else                      y_nxt     = cursor_y + 5'd1;
              end
              8'h08: begin
                if (cursor_x != 6'd0) begin
                  x_nxt     = cursor_x - 6'd1;
                  addr_nxt  = cell_addr(cursor_y, cursor_x - 6'd1);
                  wdata_nxt = BLANK;
                  we_nxt    = 1'b1;
                  en_nxt    = 1'b1;
                end else if (cursor_y != 5'd0) begin
                  x_nxt     = LAST_COL;
                  y_nxt     = cursor_y - 5'd1;
                  addr_nxt  = cell_addr(cursor_y - 5'd1, LAST_COL);
                  wdata_nxt = BLANK;
                  we_nxt    = 1'b1;
                  en_nxt    = 1'b1;
                end else begin
                  x_nxt = cursor_x;
                end
              end
              8'h0C: begin
                after_nxt = CLEAR;
                x_nxt     = 6'd0;
                y_nxt     = 5'd0;
              end
              default: after_nxt = IDLE;
            endcase
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      EXEC: begin
        state_nxt = after;
        idx_nxt   = 11'd0;
        if (after == SCROLL_RD) begin
          addr_nxt = 12'd40;
          en_nxt   = 1'b1;
        end else if (after == CLEAR) begin
          addr_nxt  = 12'd0;
          wdata_nxt = BLANK;
          we_nxt    = 1'b1;
          en_nxt    = 1'b1;
        end else begin
          addr_nxt = dis_addr;
        end
      end
      SCROLL_RD: begin
        state_nxt = SCROLL_WR;
        addr_nxt  = {1'b0, idx};
        we_nxt    = 1'b1;
        en_nxt    = 1'b1;
      end
      SCROLL_WR: begin
        if (idx == COPY_LAST) begin
          state_nxt = SCROLL_CLR;
          idx_nxt   = idx + 11'd1;
          addr_nxt  = {1'b0, idx} + 12'd1;
          wdata_nxt = BLANK;
          we_nxt    = 1'b1;
          en_nxt    = 1'b1;
        end else begin
          state_nxt = SCROLL_RD;
          idx_nxt   = idx + 11'd1;
          addr_nxt  = {1'b0, idx} + 12'd41;
          en_nxt    = 1'b1;
        end
      end
      SCROLL_CLR, CLEAR: begin
        if (idx == CELL_LAST) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt   = idx + 11'd1;
          addr_nxt  = {1'b0, idx} + 12'd1;
          wdata_nxt = BLANK;
          we_nxt    = 1'b1;
          en_nxt    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, cursor and registered memory-port outputs.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state      <= IDLE;
      after      <= IDLE;
      idx        <= 11'd0;
      cursor_x   <= 6'd0;
      cursor_y   <= 5'd0;
      dis_addr   <= 12'd0;
      wdata      <= 8'd0;
      dis_we     <= 1'b0;
      dis_en     <= 1'b0;
      char_ready <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      after      <= after_nxt;
      idx        <= idx_nxt;
      cursor_x   <= x_nxt;
      cursor_y   <= y_nxt;
      dis_addr   <= addr_nxt;
      wdata      <= wdata_nxt;
      dis_we     <= we_nxt;
      dis_en     <= en_nxt;
      char_ready <= (state_nxt == IDLE);
      busy       <= (state_nxt == SCROLL_RD) || (state_nxt == SCROLL_WR) ||
                    (state_nxt == SCROLL_CLR) || (state_nxt == CLEAR);
    end
  end

endmodule

// File: tb/tb_text_term.sv
// Self-checking bench for text_term: directed cases from the feature list plus
// randomized byte streams compared against a screen-array reference model.
module tb_text_term;

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [11:0] dis_addr;
  logic [7:0]  dis_wdata;
  logic        dis_we;
  logic        dis_en;
  logic [7:0]  dis_rdata;
  logic [5:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:1199];
  int          wcount = 0;
  logic [11:0] last_addr = 12'd0;
  logic [7:0]  last_data = 8'd0;

  logic [7:0]  scr [0:1199];
  int          mx, my, nscroll;

  text_term dut (
    .clk(clk), .clr(clr), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .dis_addr(dis_addr), .dis_wdata(dis_wdata),
    .dis_we(dis_we), .dis_en(dis_en), .dis_rdata(dis_rdata),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Display memory: synchronous read with one-cycle latency, logged writes.
  always @(posedge clk) begin
    if (dis_en && dis_we) begin
      if (dis_addr < 12'd1200) mem[dis_addr] <= dis_wdata;
      wcount    <= wcount + 1;
      last_addr <= dis_addr;
      last_data <= dis_wdata;
    end else if (dis_en) begin
      dis_rdata <= (dis_addr < 12'd1200) ? mem[dis_addr] : 8'h00;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic scroll_model();
    for (int r = 0; r < 29; r++)
      for (int c = 0; c < 40; c++) scr[r*40 + c] = scr[(r+1)*40 + c];
    for (int c = 0; c < 40; c++) scr[29*40 + c] = 8'h20;
    nscroll++;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[my*40 + mx] = b;
      mx++;
      if (mx == 40) begin
        mx = 0;
        if (my == 29) scroll_model(); else my++;
      end
    end else if (b == 8'h0D) begin
      mx = 0;
    end else if (b == 8'h0A) begin
      mx = 0;
      if (my == 29) scroll_model(); else my++;
    end else if (b == 8'h08) begin
      if (mx > 0) begin
        mx--;
        scr[my*40 + mx] = 8'h20;
      end else if (my > 0) begin
        mx = 39;
        my--;
        scr[my*40 + mx] = 8'h20;
      end
    end else if (b == 8'h0C) begin
      for (int i = 0; i < 1200; i++) scr[i] = 8'h20;
      mx = 0;
      my = 0;
    end
  endtask

  // Returns #1 after the accepting edge (inside the EXEC cycle).
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!char_ready && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 5000) check_val("ready_timeout", 32'd0, 32'd1);
    char_in    = b;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((!char_ready || busy) && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 5000) check_val("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    @(negedge clk);
    @(negedge clk);
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic put(input logic [7:0] b);
    send_byte(b);
    model_byte(b);
    wait_idle();
  endtask

  task automatic check_screen(input string tag);
    for (int i = 0; i < 1200; i++) check_val(tag, {24'd0, mem[i]}, {24'd0, scr[i]});
  endtask

  task automatic check_cursor(input string tag);
    check_val({tag, "_x"}, {26'd0, cursor_x}, mx);
    check_val({tag, "_y"}, {27'd0, cursor_y}, my);
  endtask

  initial begin
    int n;
    int r;
    int wc;
    logic [7:0] b;
    clr = 1'b0;
    char_valid = 1'b0;
    char_in = 8'h00;
    mx = 0; my = 0; nscroll = 0;
    for (int i = 0; i < 1200; i++) scr[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", char_ready, 0);
    check_val("rst_we", dis_we, 0);
    check_val("rst_en", dis_en, 0);
    check_val("rst_addr", dis_addr, 0);
    check_val("rst_wdata", dis_wdata, 0);
    check_val("rst_x", cursor_x, 0);
    check_val("rst_y", cursor_y, 0);
    check_val("rst_busy", busy, 0);
    clr = 1'b1;
    @(negedge clk);
    check_val("ready_rise", char_ready, 1);

    // Single printable byte and its write timing.
    send_byte(8'h41);
    model_byte(8'h41);
    check_val("a_we", dis_we, 1);
    check_val("a_en", dis_en, 1);
    check_val("a_addr", dis_addr, 0);
    check_val("a_wdata", dis_wdata, 8'h41);
    check_val("a_ready", char_ready, 0);
    check_cursor("a");
    @(posedge clk);
    #1;
    check_val("a_we_drop", dis_we, 0);
    check_val("a_ready_back", char_ready, 1);

    // Form feed clears the screen.
    send_byte(8'h0C);
    model_byte(8'h0C);
    measure_busy(n);
    check_val("clear_cycles", n, 1200);
    check_val("clear_ready", char_ready, 1);
    check_val("clear_en_idle", dis_en, 0);
    check_cursor("clear");
    check_screen("clear_mem");

    // 41 printables: wrap onto row 1.
    for (int i = 0; i < 41; i++) begin
      b = 8'($urandom_range(32, 126));
      put(b);
    end
    check_val("wrap_addr", last_addr, 40);
    check_val("wrap_data", last_data, b);
    check_val("wrap_x", cursor_x, 1);
    check_val("wrap_y", cursor_y, 1);

    // Move to (5,29) and scroll with LF.
    put(8'h0D);
    repeat (28) put(8'h0A);
    repeat (5) put(8'($urandom_range(32, 126)));
    check_val("pre_scroll_x", cursor_x, 5);
    check_val("pre_scroll_y", cursor_y, 29);
    send_byte(8'h0A);
    model_byte(8'h0A);
    measure_busy(n);
    check_val("scroll_cycles", n, 2360);
    check_val("scroll_ready", char_ready, 1);
    check_val("scroll_x", cursor_x, 0);
    check_val("scroll_y", cursor_y, 29);
    check_screen("scroll_mem");

    // Backspace across a row boundary and at home.
    put(8'h0C);
    repeat (3) put(8'h0A);
    put(8'h08);
    check_val("bs_x", cursor_x, 39);
    check_val("bs_y", cursor_y, 2);
    check_val("bs_addr", last_addr, 119);
    check_val("bs_data", last_data, 8'h20);
    put(8'h0C);
    wc = wcount;
    put(8'h08);
    check_val("bs_home_nowrite", wcount, wc);
    check_cursor("bs_home");

    // Randomized stream against the screen model.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 78)      b = 8'($urandom_range(32, 126));
      else if (r < 82) b = 8'h0D;
      else if (r < 88) b = (nscroll >= 8) ? 8'h0D : 8'h0A;
      else if (r < 95) b = 8'h08;
      else if (r < 97) b = 8'h0C;
      else             b = 8'h80 | 8'($urandom_range(0, 127));
      put(b);
      check_cursor("rand");
    end
    check_screen("rand_mem");

    // Reset in the middle of a scroll.
    put(8'h0D);
    while (my < 29) put(8'h0A);
    send_byte(8'h0A);
    repeat (500) @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
    check_val("abort_busy", busy, 0);
    check_val("abort_we", dis_we, 0);
    check_val("abort_en", dis_en, 0);
    check_val("abort_x", cursor_x, 0);
    check_val("abort_y", cursor_y, 0);
    check_val("abort_ready", char_ready, 0);
    @(negedge clk);
    clr = 1'b1;
    send_byte(8'h5A);
    check_val("z_we", dis_we, 1);
    check_val("z_addr", dis_addr, 0);
    check_val("z_wdata", dis_wdata, 8'h5A);
    check_val("z_x", cursor_x, 1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
